// File: rtl/multiport_regfile_if.sv
// Bus interface of multiport_regfile: packed read ports, single/pair write port,
// busy-marking port, and the ready / wr_err status flags.
interface multiport_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 3
) ();
    logic                     ready;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic                     wr_pair;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [DATA_W-1:0]        wr_data_hi;
    logic                     wr_err;
    logic                     busy_set;
    logic [ADDR_W-1:0]        busy_addr;

    modport master (
        input  ready, rd_data, rd_busy, wr_err,
        output rd_addr, wr_en, wr_pair, wr_addr, wr_data, wr_data_hi, busy_set, busy_addr
    );

    modport slave (
        output ready, rd_data, rd_busy, wr_err,
        input  rd_addr, wr_en, wr_pair, wr_addr, wr_data, wr_data_hi, busy_set, busy_addr
    );
endinterface

// File: rtl/multiport_regfile.sv
// Multiport register file with a post-reset clear sweep, single/pair writes and per-entry busy bits.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module multiport_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 3
) (
    input  logic                clk,
    input  logic                rst,
    multiport_regfile_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic                wr_err_q, wr_err_d;

    logic                ready_s, sweep_s;
    logic                single_ok_s, pair_ok_s, pair_bad_s, set_ok_s;
    logic [ADDR_W-1:0]   wr_addr_hi_s;
    logic [DEPTH-1:0]    wr_lo_hit_s, wr_hi_hit_s, set_hit_s;
    logic [ADDR_W-1:0]   rd_idx_s [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_data_s;
    logic [NUM_RD-1:0]   rd_busy_s;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_idx
        assign rd_idx_s[g] = bus.rd_addr[g*ADDR_W +: ADDR_W];
    end

    // State register: rst restarts the sweep from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= ADDR_ZERO;
            busy_q    <= {DEPTH{1'b0}};
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            wr_err_q  <= wr_err_d;
        end
    end

    // Array storage: rst blocks any sweep or write commit in the same edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= mem_d[e];
            end
        end
    end

    // Next-state logic: sweep every entry once, then stay in RUN
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_INIT: begin
                clr_cnt_d = clr_cnt_q + ADDR_ONE;
                if (clr_cnt_q == ADDR_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: begin
                state_d   = ST_INIT;
                clr_cnt_d = ADDR_ZERO;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        ready_s = 1'b0;
        sweep_s = 1'b0;
        case (state_q)
            ST_INIT: sweep_s = 1'b1;
            ST_RUN:  ready_s = 1'b1;
            default: sweep_s = 1'b0;
        endcase
    end

    // Write-port qualification; pair writes at 0 or DEPTH-1 would wrap or hit r0
    always_comb begin
        wr_addr_hi_s = bus.wr_addr + ADDR_ONE;
        pair_bad_s   = ready_s & bus.wr_en & bus.wr_pair &
                       ((bus.wr_addr == ADDR_ZERO) | (bus.wr_addr == ADDR_LAST));
        pair_ok_s    = ready_s & bus.wr_en & bus.wr_pair & ~pair_bad_s;
        single_ok_s  = ready_s & bus.wr_en & ~bus.wr_pair & (bus.wr_addr != ADDR_ZERO);
        set_ok_s     = ready_s & bus.busy_set & (bus.busy_addr != ADDR_ZERO);
        for (int e = 0; e < DEPTH; e++) begin
            wr_lo_hit_s[e] = (single_ok_s | pair_ok_s) & (bus.wr_addr == ADDR_W'(e));
            wr_hi_hit_s[e] = pair_ok_s & (wr_addr_hi_s == ADDR_W'(e));
            set_hit_s[e]   = set_ok_s & (bus.busy_addr == ADDR_W'(e));
        end
    end

    // Array, busy and error next state; busy_set wins over a same-cycle clear
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_d[e] = mem_q[e];
            if (sweep_s && (clr_cnt_q == ADDR_W'(e))) begin
                mem_d[e] = {DATA_W{1'b0}};
            end else if (wr_lo_hit_s[e]) begin
                mem_d[e] = bus.wr_data;
            end else if (wr_hi_hit_s[e]) begin
                mem_d[e] = bus.wr_data_hi;
            end else begin
                mem_d[e] = mem_q[e];
            end
            busy_d[e] = set_hit_s[e] | (busy_q[e] & ~wr_lo_hit_s[e] & ~wr_hi_hit_s[e]);
        end
        wr_err_d = pair_bad_s;
    end

    // Combinational read ports
    always_comb begin
        rd_data_s = {(NUM_RD*DATA_W){1'b0}};
        rd_busy_s = {NUM_RD{1'b0}};
        for (int i = 0; i < NUM_RD; i++) begin
            if (ready_s && (rd_idx_s[i] != ADDR_ZERO)) begin
`ifdef REGFILE_BYPASS_EN
                if (wr_lo_hit_s[rd_idx_s[i]]) begin
                    rd_data_s[i*DATA_W +: DATA_W] = bus.wr_data;
                    rd_busy_s[i]                  = set_hit_s[rd_idx_s[i]];
                end else if (wr_hi_hit_s[rd_idx_s[i]]) begin
                    rd_data_s[i*DATA_W +: DATA_W] = bus.wr_data_hi;
                    rd_busy_s[i]                  = set_hit_s[rd_idx_s[i]];
                end else begin
                    rd_data_s[i*DATA_W +: DATA_W] = mem_q[rd_idx_s[i]];
                    rd_busy_s[i]                  = busy_q[rd_idx_s[i]];
                end
`else
                rd_data_s[i*DATA_W +: DATA_W] = mem_q[rd_idx_s[i]];
                rd_busy_s[i]                  = busy_q[rd_idx_s[i]];
`endif
            end else begin
                rd_data_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                rd_busy_s[i]                  = 1'b0;
            end
        end
    end

    assign bus.ready   = ready_s;
    assign bus.wr_err  = wr_err_q;
    assign bus.rd_data = rd_data_s;
    assign bus.rd_busy = rd_busy_s;
endmodule

// File: tb/tb_multiport_regfile.sv
// Directed, table-driven bench for multiport_regfile (default parameters).
module tb_multiport_regfile;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multiport_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();
    multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        wr_en;
        logic        wr_pair;
        logic [4:0]  wr_addr;
        logic [31:0] wd;
        logic [31:0] wdh;
        logic        bset;
        logic [4:0]  baddr;
        logic [4:0]  ra0, ra1, ra2;
        logic [31:0] e0, e1, e2;
        logic [2:0]  ebusy;
        logic        eerr;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en      = 1'b0;
        bus.wr_pair    = 1'b0;
        bus.wr_addr    = 5'd0;
        bus.wr_data    = 32'h0;
        bus.wr_data_hi = 32'h0;
        bus.busy_set   = 1'b0;
        bus.busy_addr  = 5'd0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        bus.rd_addr = {a2, a1, a0};
    endtask

    task automatic write1(input logic [4:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_pair = 1'b0;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    // Counts edges until ready, bounded; returns the count (100 on timeout)
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (bus.ready !== 1'b1 && cnt < 100) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        int cnt;
        idle();
        set_rd(5'd31, 5'd31, 5'd31);
        rst = 1'b1;

        // Startup: one-cycle reset pulse, then a 32-edge sweep
        step();
        chk("ready_after_rst", {127'd0, bus.ready}, 128'd0);
        rst = 1'b0;
        cnt = 0;
        while (bus.ready !== 1'b1 && cnt < 100) begin
            if (cnt == 1) begin
                chk("init_rd_data_zero", {32'd0, bus.rd_data}, 128'd0);
                bus.busy_set  = 1'b1;
                bus.busy_addr = 5'd31;
            end else begin
                bus.busy_set  = 1'b0;
                bus.busy_addr = 5'd0;
            end
            step();
            cnt++;
        end
        idle();
        chk("ready_cycles", cnt, 128'd32);
        chk("init_busy_ignored", {125'd0, bus.rd_busy}, 128'd0);

        for (int a = 0; a < 32; a += 4) begin
            set_rd(5'(a), 5'(a + 1), 5'(a + 3));
            #1;
            chk($sformatf("swept_r%0d", a), {32'd0, bus.rd_data}, 128'd0);
        end

        vecs[0]  = '{1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 32'h0, 1'b0, 5'd0,  5'd5,  5'd3,  5'd5,
                     32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 3'b000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 5'd0,  32'h1, 32'h0, 1'b0, 5'd0,  5'd0,  5'd5,  5'd0,
                     32'h0, 32'hDEADBEEF, 32'h0, 3'b000, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 5'd30, 32'h11111111, 32'h22222222, 1'b0, 5'd0, 5'd30, 5'd31, 5'd5,
                     32'h11111111, 32'h22222222, 32'hDEADBEEF, 3'b000, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 5'd31, 32'h33, 32'h44, 1'b0, 5'd0,  5'd31, 5'd30, 5'd0,
                     32'h22222222, 32'h11111111, 32'h0, 3'b000, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 5'd0,  32'h0, 32'h0, 1'b0, 5'd0,  5'd31, 5'd30, 5'd1,
                     32'h22222222, 32'h11111111, 32'h0, 3'b000, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 5'd0,  32'h55, 32'h66, 1'b0, 5'd0,  5'd0,  5'd1,  5'd5,
                     32'h0, 32'h0, 32'hDEADBEEF, 3'b000, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0, 32'h0, 1'b0, 5'd0,  5'd1,  5'd2,  5'd0,
                     32'h0, 32'h0, 32'h0, 3'b000, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'h0, 32'h0, 1'b1, 5'd7,  5'd7,  5'd5,  5'd7,
                     32'h0, 32'hDEADBEEF, 32'h0, 3'b101, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 5'd7,  32'h77, 32'h0, 1'b1, 5'd7,  5'd7,  5'd7,  5'd0,
                     32'h77, 32'h77, 32'h0, 3'b011, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 5'd7,  32'h78, 32'h0, 1'b0, 5'd0,  5'd7,  5'd0,  5'd7,
                     32'h78, 32'h0, 32'h78, 3'b000, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0, 32'h0, 1'b1, 5'd0,  5'd0,  5'd0,  5'd0,
                     32'h0, 32'h0, 32'h0, 3'b000, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 5'd12, 32'hA, 32'hB, 1'b1, 5'd13, 5'd12, 5'd13, 5'd12,
                     32'hA, 32'hB, 32'hA, 3'b010, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 5'd13, 32'hC, 32'h0, 1'b0, 5'd0,  5'd13, 5'd12, 5'd13,
                     32'hC, 32'hA, 32'hC, 3'b000, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 5'd0,  32'h0, 32'h0, 1'b1, 5'd20, 5'd20, 5'd19, 5'd20,
                     32'h0, 32'h0, 32'h0, 3'b101, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 5'd19, 32'h19, 32'h20, 1'b0, 5'd0, 5'd19, 5'd20, 5'd0,
                     32'h19, 32'h20, 32'h0, 3'b000, 1'b0};

        for (int i = 0; i < 15; i++) begin
            bus.wr_en      = vecs[i].wr_en;
            bus.wr_pair    = vecs[i].wr_pair;
            bus.wr_addr    = vecs[i].wr_addr;
            bus.wr_data    = vecs[i].wd;
            bus.wr_data_hi = vecs[i].wdh;
            bus.busy_set   = vecs[i].bset;
            bus.busy_addr  = vecs[i].baddr;
            set_rd(vecs[i].ra0, vecs[i].ra1, vecs[i].ra2);
            step();
            idle();
            #1;
            chk($sformatf("vec%0d_data", i), {32'd0, bus.rd_data},
                {32'd0, vecs[i].e2, vecs[i].e1, vecs[i].e0});
            chk($sformatf("vec%0d_busy", i), {125'd0, bus.rd_busy}, {125'd0, vecs[i].ebusy});
            chk($sformatf("vec%0d_err", i), {127'd0, bus.wr_err}, {127'd0, vecs[i].eerr});
        end

        // Same-cycle visibility of a write to r9, with r9 marked busy beforehand
        bus.busy_set  = 1'b1;
        bus.busy_addr = 5'd9;
        set_rd(5'd9, 5'd9, 5'd0);
        step();
        idle();
        write1(5'd9, 32'hA5);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_data", {96'd0, bus.rd_data[31:0]}, 128'hA5);
        chk("bypass_busy", {127'd0, bus.rd_busy[0]}, 128'd0);
`else
        chk("nobypass_old_data", {96'd0, bus.rd_data[31:0]}, 128'd0);
        chk("nobypass_old_busy", {127'd0, bus.rd_busy[0]}, 128'd1);
`endif
        step();
        idle();
        #1;
        chk("r9_after_edge", {96'd0, bus.rd_data[63:32]}, 128'hA5);
        chk("r9_busy_after_edge", {127'd0, bus.rd_busy[1]}, 128'd0);

        // Reset in the middle of a write sequence, then again partway through the sweep
        bus.busy_set  = 1'b1;
        bus.busy_addr = 5'd7;
        step();
        write1(5'd10, 32'h10);
        step();
        write1(5'd11, 32'h11);
        bus.busy_set  = 1'b1;
        bus.busy_addr = 5'd12;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        set_rd(5'd5, 5'd11, 5'd7);
        for (int k = 0; k < 10; k++) begin
            step();
        end
        chk("mid_sweep_ready", {127'd0, bus.ready}, 128'd0);
        chk("mid_sweep_rd_zero", {32'd0, bus.rd_data}, 128'd0);
        write1(5'd13, 32'h13);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        wait_ready(cnt);
        chk("resweep_ready_cycles", cnt, 128'd32);
        #1;
        chk("resweep_data", {32'd0, bus.rd_data}, 128'd0);
        chk("resweep_busy", {125'd0, bus.rd_busy}, 128'd0);
        set_rd(5'd12, 5'd10, 5'd13);
        #1;
        chk("resweep_data2", {32'd0, bus.rd_data}, 128'd0);
        chk("resweep_busy2", {125'd0, bus.rd_busy}, 128'd0);
        chk("resweep_err", {127'd0, bus.wr_err}, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
